// File: rtl/daisy_shm_arb.sv
// daisy_shm_arb: round-robin arbiter sharing one shared-memory command/response channel among NREQ requesters.
// Define DAISY_SHM_ARB_TIMEOUT_EN to add a WAIT-state response timeout that completes with err=1.
module daisy_shm_arb #(
    parameter int NREQ      = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rest_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic                 shm_valid,
    input  logic                 shm_ready,
    output logic                 shm_wr,
    output logic [AW-1:0]        shm_addr,
    output logic [DW-1:0]        shm_wdata,
    input  logic                 shm_resp_valid,
    input  logic [DW-1:0]        shm_resp_data
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state_q;
    logic [IW-1:0] ptr_q, gidx_q, win, idx, nxt;
    logic [NREQ-1:0] gnt_q, done_q;
    logic [DW-1:0] rdata_q, wdata_q;
    logic [AW-1:0] addr_q;
    logic valid_q, wr_q, any;
    // Scan downward so the requester closest to the pointer is the last (winning) assignment.
    always_comb begin
        win = ptr_q;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    assign nxt = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
`ifdef DAISY_SHM_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DAISY_SHM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (any) begin
                    gidx_q  <= win;
                    gnt_q   <= NREQ'(1) << win;
                    wr_q    <= req_wr[win];
                    addr_q  <= req_addr[int'(win)*AW +: AW];
                    wdata_q <= req_wdata[int'(win)*DW +: DW];
                    valid_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: if (shm_ready) begin
                    valid_q <= 1'b0;
`ifdef DAISY_SHM_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: if (shm_resp_valid) begin
                    if (!wr_q) rdata_q <= shm_resp_data;
                    done_q  <= gnt_q;
                    state_q <= DONE;
                end
`ifdef DAISY_SHM_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TO_CYCLES - 1)) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    done_q  <= gnt_q;
                    state_q <= DONE;
                end else cnt_q <= cnt_q + 1'b1;
`endif
                default: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    ptr_q   <= nxt;
`ifdef DAISY_SHM_ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign shm_valid = valid_q;
    assign shm_wr    = wr_q;
    assign shm_addr  = addr_q;
    assign shm_wdata = wdata_q;
endmodule

// File: doc/daisy_shm_arb.md
DAISY_SHM_ARB -- requirements
Module: daisy_shm_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the shared-memory channel (2..8).
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter TO_CYCLES, default 255: response timeout in clk cycles (1..65535).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rest_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  NREQ  per-requester transaction request level.
REQ-008 req_wr  input  NREQ  per-requester direction: 1 write, 0 read.
REQ-009 req_addr  input  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW].
REQ-010 req_wdata  input  NREQ*DW  per-requester write data, same packing.
REQ-011 gnt  output  NREQ  one-hot grant; zero when idle.
REQ-012 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-013 rdata  output  DW  read data, valid in the done cycle.
REQ-014 err  output  1  timeout flag, valid in the done cycle.
REQ-015 shm_valid / shm_ready  output / input  1 / 1  command handshake toward the shared-memory channel.
REQ-016 shm_wr, shm_addr, shm_wdata  output  1, AW, DW  command payload, copied from the granted requester.
REQ-017 shm_resp_valid, shm_resp_data  input  1, DW  response from the channel.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: if any req bit is set, the arbiter SHALL select the winner round-robin starting at the pointer, register it into gnt, and enter ISSUE next cycle.
REQ-020 ISSUE: shm_valid SHALL be 1 with payload from the granted requester; on shm_valid&&shm_ready the FSM SHALL enter WAIT.
REQ-021 WAIT: on shm_resp_valid the FSM SHALL capture shm_resp_data into rdata and enter DONE; shm_resp_valid outside WAIT SHALL be ignored.
REQ-022 DONE: done[granted] SHALL be 1 for exactly this cycle, gnt SHALL clear on exit, the pointer SHALL become (granted+1) mod NREQ, and the FSM SHALL return to IDLE.
REQ-023 Minimum latency, req rise to done pulse with shm_ready=1 and response one cycle after handshake: 4 cycles.
REQ-024 Requesters SHALL hold req and payload until done; deasserting req after grant SHALL NOT abort the transaction.
REQ-025 With all NREQ requesters continuously asserting, grants SHALL rotate 0,1,...,NREQ-1,0 with no requester granted twice before all others are granted once.
REQ-026 A req that is asserted in the same cycle as a done pulse SHALL be considered in the following IDLE cycle.
REQ-027 rdata SHALL hold its last value except in DONE after a read; for writes rdata SHALL be unchanged.
REQ-028 shm_valid, once asserted, SHALL remain 1 with stable payload until shm_ready.

Reset
REQ-029 On rest_n low, asynchronously: state IDLE, pointer 0, gnt 0, done 0, shm_valid 0, err 0, rdata 0, timeout counter 0.
REQ-030 Reset mid-transaction SHALL abandon it without a done pulse; after release the FSM SHALL start from IDLE.

Configuration
REQ-031 Macro DAISY_SHM_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT; if TO_CYCLES cycles elapse without shm_resp_valid the FSM SHALL enter DONE with err=1 and rdata=0; the counter SHALL clear on entering WAIT.
REQ-032 Macro undefined: WAIT SHALL persist until shm_resp_valid, err SHALL be tied 0, and no counter SHALL be instantiated.

Verification
REQ-033 Single read: req[2]=1, addr 0x100, shm_ready=1, response 0xDEADBEEF one cycle after handshake -> gnt=4'b0100, done[2] pulse at cycle 4, rdata=0xDEADBEEF, err=0.
REQ-034 All four requesting continuously, 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-035 shm_ready held 0 for 5 cycles during ISSUE -> shm_valid stays 1, payload stable, then WAIT after ready.
REQ-036 TIMEOUT_EN, TO_CYCLES=10, no response -> done pulse with err=1, rdata=0, 10 cycles after entering WAIT; next request proceeds normally.
REQ-037 rest_n pulsed low during WAIT -> all outputs zero immediately, no done pulse, late shm_resp_valid ignored.
REQ-038 req[1] deasserted one cycle after grant -> transaction still completes with done[1] pulse.
